// File: rtl/sdio_crc16_multi.sv
// Per-lane CRC16 engine for the SDIO data path.
// One CRC register per DAT lane, updated one bit per lane per sample.
// A small controller sequences payload accumulation, 16-bit CRC
// serialisation (EMIT) and 16-bit CRC comparison (CHECK).

// One lane: CRC register plus sticky mismatch flag.
module sdio_crc16_lane #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        load_i,     // reload INIT, highest priority
    input  logic        upd_i,      // Galois update with data_i
    input  logic        shift_i,    // plain shift (CRC serialisation)
    input  logic        cmp_i,      // compare data_i with bit 15, then shift
    input  logic        err_clr_i,  // clear sticky mismatch flag
    input  logic        data_i,
    output logic [15:0] crc_o,
    output logic        err_o
);

    logic fb;

    assign fb = data_i ^ crc_o[15];

    // CRC register: reload, Galois update or plain left shift
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            crc_o <= INIT;
        end else if (load_i) begin
            crc_o <= INIT;
        end else if (upd_i) begin
            crc_o <= {crc_o[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end else if (shift_i || cmp_i) begin
            crc_o <= {crc_o[14:0], 1'b0};
        end
    end

    // Sticky mismatch flag, accumulated across the 16 compared bits
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_o <= 1'b0;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end else if (cmp_i) begin
            err_o <= err_o | fb;
        end
    end

endmodule

module sdio_crc16_multi #(
    parameter int          NUM_LANES = 4,
    parameter logic [15:0] POLY      = 16'h1021,
    parameter logic [15:0] INIT      = 16'h0000
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      clr_i,
    input  logic                      sample_i,
    input  logic [NUM_LANES-1:0]      data_i,
    input  logic                      emit_start_i,
    input  logic                      check_start_i,
    output logic [16*NUM_LANES-1:0]   crc_par_o,
    output logic [NUM_LANES-1:0]      crc_serial_o,
    output logic                      busy_o,
    output logic                      emit_done_o,
    output logic                      check_done_o,
    output logic [NUM_LANES-1:0]      check_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic lane_load, lane_upd, lane_shift, lane_cmp, lane_err_clr;
    logic emit_fin, check_fin;

    // State and bit counter register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: clr aborts everything, emit wins over check in IDLE,
    // EMIT runs free, CHECK only advances on sample_i
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (emit_start_i) begin
                        state_d = EMIT;
                        cnt_d   = 4'd0;
                    end else if (check_start_i) begin
                        state_d = CHECK;
                        cnt_d   = 4'd0;
                    end
                end
                EMIT: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = IDLE;
                end
                CHECK: begin
                    if (sample_i) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd15) state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Outputs: lane controls, busy and the exit strobes feeding the done pulses
    always_comb begin
        lane_load    = clr_i;
        lane_upd     = 1'b0;
        lane_shift   = 1'b0;
        lane_cmp     = 1'b0;
        lane_err_clr = clr_i;
        emit_fin     = 1'b0;
        check_fin    = 1'b0;
        busy_o       = (state_q != IDLE);
        if (!clr_i) begin
            case (state_q)
                IDLE: begin
                    // A start consumes the cycle; a coincident sample is dropped
                    lane_upd     = sample_i && !emit_start_i && !check_start_i;
                    lane_err_clr = !emit_start_i && check_start_i;
                end
                EMIT: begin
                    lane_shift = 1'b1;
                    emit_fin   = (cnt_q == 4'd15);
                end
                CHECK: begin
                    lane_cmp  = sample_i;
                    check_fin = sample_i && (cnt_q == 4'd15);
                end
                default: ;
            endcase
        end
    end

    // Done pulses appear on the first cycle back in IDLE
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            emit_done_o  <= 1'b0;
            check_done_o <= 1'b0;
        end else begin
            emit_done_o  <= emit_fin;
            check_done_o <= check_fin;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sdio_crc16_lane #(
            .POLY (POLY),
            .INIT (INIT)
        ) u_lane (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .load_i    (lane_load),
            .upd_i     (lane_upd),
            .shift_i   (lane_shift),
            .cmp_i     (lane_cmp),
            .err_clr_i (lane_err_clr),
            .data_i    (data_i[g]),
            .crc_o     (crc_par_o[16*g +: 16]),
            .err_o     (check_err_o[g])
        );
        assign crc_serial_o[g] = crc_par_o[16*g + 15];
    end

endmodule

// File: tb/tb_sdio_crc16_multi.sv
// Directed bench for sdio_crc16_multi: a 1-lane instance for the
// "123456789" check value and a 4-lane instance for emit/check/abort cases.
module tb_sdio_crc16_multi;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    // 1-lane instance
    logic        clr1, sample1, emit1, check1;
    logic [0:0]  data1;
    logic [15:0] crc_par1;
    logic [0:0]  serial1, err1;
    logic        busy1, edone1, cdone1;

    // 4-lane instance
    logic        clr4, sample4, emit4, check4;
    logic [3:0]  data4;
    logic [63:0] crc_par4;
    logic [3:0]  serial4, err4;
    logic        busy4, edone4, cdone4;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [63:0] sb[$];

    always #5 clk = ~clk;

    sdio_crc16_multi #(.NUM_LANES(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .clr_i(clr1), .sample_i(sample1),
        .data_i(data1), .emit_start_i(emit1), .check_start_i(check1),
        .crc_par_o(crc_par1), .crc_serial_o(serial1), .busy_o(busy1),
        .emit_done_o(edone1), .check_done_o(cdone1), .check_err_o(err1)
    );

    sdio_crc16_multi #(.NUM_LANES(4)) dut4 (
        .clk_i(clk), .rstn_i(rstn), .clr_i(clr4), .sample_i(sample4),
        .data_i(data4), .emit_start_i(emit4), .check_start_i(check4),
        .crc_par_o(crc_par4), .crc_serial_o(serial4), .busy_o(busy4),
        .emit_done_o(edone4), .check_done_o(cdone4), .check_err_o(err4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] obs);
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("FAIL %s: got %0h expected <scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, sb.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_ff();
        repeat (4096) begin
            sample4 = 1'b1;
            data4   = 4'hF;
            tick();
        end
        sample4 = 1'b0;
        data4   = 4'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string       msg;
        logic [7:0]  byte_v;
        logic [15:0] p_ok, p_bad;
        logic        busy_ok, no_done;

        msg   = "123456789";
        p_ok  = 16'h7FA1;
        p_bad = 16'h7FA0;
        clr1 = 0; sample1 = 0; emit1 = 0; check1 = 0; data1 = '0;
        clr4 = 0; sample4 = 0; emit4 = 0; check4 = 0; data4 = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy4),    64'd0);
        chk("rst_edone",  64'(edone4),   64'd0);
        chk("rst_cdone",  64'(cdone4),   64'd0);
        chk("rst_err",    64'(err4),     64'd0);
        chk("rst_serial", 64'(serial4),  64'd0);
        chk("rst_crc4",   64'(crc_par4), 64'd0);
        chk("rst_crc1",   64'(crc_par1), 64'd0);
        rstn = 1'b1;
        tick();

        // 1 lane, "123456789" MSB first
        for (int i = 0; i < 9; i++) begin
            byte_v = msg[i];
            for (int b = 7; b >= 0; b--) begin
                sample1  = 1'b1;
                data1[0] = byte_v[b];
                tick();
            end
        end
        sample1 = 1'b0;
        data1   = '0;
        chk("crc1_123456789", 64'(crc_par1), 64'h31C3);

        // 4 lanes, 512 bytes of 0xFF per lane
        feed_ff();
        chk("crc4_ff_payload", crc_par4, {4{16'h7FA1}});

        // Emit: 16 serial bits, stray start/sample while busy are ignored
        for (int k = 0; k < 16; k++) sb.push_back(64'({4{p_ok[15-k]}}));
        emit4 = 1'b1;
        tick();
        emit4 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pop_chk("emit_serial", 64'(serial4));
            chk("emit_busy",  64'(busy4),  64'd1);
            chk("emit_edone", 64'(edone4), 64'd0);
            check4  = (k == 3);
            sample4 = (k == 5);
            data4   = (k == 5) ? 4'hF : 4'h0;
            tick();
        end
        check4 = 1'b0; sample4 = 1'b0; data4 = 4'h0;
        chk("emit_done_pulse", 64'(edone4),   64'd1);
        chk("emit_idle",       64'(busy4),    64'd0);
        chk("emit_lanes_zero", crc_par4,      64'd0);
        chk("emit_err_keep",   64'(err4),     64'd0);
        tick();
        chk("emit_done_single", 64'(edone4),  64'd0);

        // Check: lanes 0-2 correct CRC, lane 3 last bit wrong, gaps 0-3
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        feed_ff();
        check4 = 1'b1;
        sb.push_back(64'(4'b1000));
        tick();
        check4 = 1'b0;
        chk("check_busy_entry", 64'(busy4), 64'd1);
        busy_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sample4 = 1'b1;
            data4   = {p_bad[15-k], p_ok[15-k], p_ok[15-k], p_ok[15-k]};
            tick();
            sample4 = 1'b0;
            data4   = 4'h0;
            if (k < 15) begin
                if (!busy4) busy_ok = 1'b0;
                repeat (k % 4) begin
                    tick();
                    if (!busy4) busy_ok = 1'b0;
                end
            end
        end
        chk("check_done_pulse", 64'(cdone4), 64'd1);
        pop_chk("check_err", 64'(err4));
        chk("check_idle",       64'(busy4), 64'd0);
        chk("check_busy_gaps",  64'(busy_ok), 64'd1);
        chk("check_lanes_zero", crc_par4, 64'd0);
        tick();
        chk("check_done_single", 64'(cdone4), 64'd0);
        chk("check_err_sticky",  64'(err4),   64'd8);

        // Both starts together -> EMIT, error flags untouched; clr at bit 7
        repeat (8) begin
            sample4 = 1'b1;
            data4   = 4'hA;
            tick();
        end
        sample4 = 1'b0; data4 = 4'h0;
        emit4 = 1'b1; check4 = 1'b1;
        tick();
        emit4 = 1'b0; check4 = 1'b0;
        chk("both_start_busy", 64'(busy4), 64'd1);
        chk("both_start_err",  64'(err4),  64'd8);
        repeat (7) tick();
        chk("abort_still_busy", 64'(busy4), 64'd1);
        clr4 = 1'b1;
        tick();
        clr4 = 1'b0;
        chk("abort_idle",  64'(busy4),  64'd0);
        chk("abort_lanes", crc_par4,    64'd0);
        chk("abort_err",   64'(err4),   64'd0);
        no_done = 1'b1;
        repeat (20) begin
            if (edone4) no_done = 1'b0;
            tick();
        end
        chk("abort_no_edone", 64'(no_done), 64'd1);

        // Async reset mid-CHECK
        check4 = 1'b1;
        tick();
        check4 = 1'b0;
        repeat (3) begin
            sample4 = 1'b1;
            data4   = 4'hF;
            tick();
        end
        sample4 = 1'b0; data4 = 4'h0;
        chk("midcheck_err",  64'(err4),  64'hF);
        chk("midcheck_busy", 64'(busy4), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy",   64'(busy4),   64'd0);
        chk("arst_err",    64'(err4),    64'd0);
        chk("arst_crc",    crc_par4,     64'd0);
        chk("arst_serial", 64'(serial4), 64'd0);
        chk("arst_cdone",  64'(cdone4),  64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        no_done = 1'b1;
        repeat (20) begin
            if (cdone4 || edone4) no_done = 1'b0;
            tick();
        end
        chk("arst_no_done", 64'(no_done), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
